// File: rtl/seg7_rx_hex.sv
// Decodes committed 7-segment patterns back to hex nibbles and
// pairs consecutive digits into a byte, with timeout and error counting.
module seg7_rx_hex #(
  parameter int TIMEOUT = 16,
  parameter int ERRW    = 4
) (
  input  logic            clk_2,
  input  logic            reset,
  input  logic [6:0]      seg_in,
  input  logic            stb,
  output logic [3:0]      digit,
  output logic            digit_valid,
  output logic [7:0]      byte_out,
  output logic            byte_valid,
  output logic            pending,
  output logic            err,
  output logic            timeout,
  output logic [ERRW-1:0] err_count
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t          state_q;
  logic            stb_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      hi_q;
  logic [3:0]      digit_q;
  logic [7:0]      byte_q;
  logic            dv_q;
  logic            bv_q;
  logic            pend_q;
  logic            err_q;
  logic            to_q;
  logic [ERRW-1:0] errc_q;

  logic       evt;
  logic       ok_d;
  logic [3:0] nib_d;

  assign evt = stb & ~stb_q;

  always_comb begin
    ok_d  = 1'b1;
    nib_d = 4'h0;
    unique case (seg_in)
      7'b0111111: nib_d = 4'h0;
      7'b0000110: nib_d = 4'h1;
      7'b1011011: nib_d = 4'h2;
      7'b1001111: nib_d = 4'h3;
      7'b1100110: nib_d = 4'h4;
      7'b1101101: nib_d = 4'h5;
      7'b1111101: nib_d = 4'h6;
      7'b0000111: nib_d = 4'h7;
      7'b1111111: nib_d = 4'h8;
      7'b1101111: nib_d = 4'h9;
      7'b1110111: nib_d = 4'hA;
      7'b1111100: nib_d = 4'hB;
      7'b0111001: nib_d = 4'hC;
      7'b1011110: nib_d = 4'hD;
      7'b1111001: nib_d = 4'hE;
      7'b1110001: nib_d = 4'hF;
      default:    ok_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= IDLE;
      stb_q   <= 1'b1;
      cnt_q   <= '0;
      hi_q    <= '0;
      digit_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      bv_q    <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      errc_q  <= '0;
    end else begin
      stb_q <= stb;
      dv_q  <= 1'b0;
      bv_q  <= 1'b0;
      err_q <= 1'b0;
      to_q  <= 1'b0;
      if (evt) begin
        cnt_q <= '0;
        if (ok_d) begin
          digit_q <= nib_d;
          dv_q    <= 1'b1;
          if (state_q == IDLE) begin
            hi_q    <= nib_d;
            state_q <= PEND;
            pend_q  <= 1'b1;
          end else begin
            byte_q  <= {hi_q, nib_d};
            bv_q    <= 1'b1;
            state_q <= IDLE;
            pend_q  <= 1'b0;
          end
        end else begin
          err_q   <= 1'b1;
          state_q <= IDLE;
          pend_q  <= 1'b0;
          if (errc_q != '1) errc_q <= errc_q + 1'b1;
        end
      end else if (state_q == PEND) begin
        // an event on the expiry edge takes the branch above instead
        if (cnt_q == LAST) begin
          to_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
          pend_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign byte_out    = byte_q;
  assign byte_valid  = bv_q;
  assign pending     = pend_q;
  assign err         = err_q;
  assign timeout     = to_q;
  assign err_count   = errc_q;

endmodule

// File: tb/tb_seg7_rx_hex.sv
// Randomized bench for seg7_rx_hex against a digit-pairing
// reference model built from the decode table and timing rules.
module tb_seg7_rx_hex;

  localparam int TIMEOUT = 16;
  localparam int ERRW    = 4;

  logic            clk_2 = 1'b0;
  logic            reset;
  logic [6:0]      seg_in;
  logic            stb;
  logic [3:0]      digit;
  logic            digit_valid;
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic            pending;
  logic            err;
  logic            timeout;
  logic [ERRW-1:0] err_count;

  seg7_rx_hex #(.TIMEOUT(TIMEOUT), .ERRW(ERRW)) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .seg_in      (seg_in),
    .stb         (stb),
    .digit       (digit),
    .digit_valid (digit_valid),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .pending     (pending),
    .err         (err),
    .timeout     (timeout),
    .err_count   (err_count)
  );

  always #5 clk_2 = ~clk_2;

  logic [6:0] pat [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit       m_prev;
  bit       m_pend;
  int       m_age;
  int       m_hi;
  int       m_digit;
  int       m_byte;
  int       m_errs;
  bit       m_dv, m_bv, m_err, m_to;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (pat[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 1; m_pend = 0; m_age = 0; m_hi = 0;
    m_digit = 0; m_byte = 0; m_errs = 0;
    m_dv = 0; m_bv = 0; m_err = 0; m_to = 0;
  endtask

  task automatic model_edge(input bit s, input logic [6:0] sg);
    bit ev;
    int n;
    ev = s && !m_prev;
    m_prev = s;
    m_dv = 0; m_bv = 0; m_err = 0; m_to = 0;
    if (ev) begin
      n = lookup(sg);
      if (n >= 0) begin
        m_digit = n;
        m_dv = 1;
        if (!m_pend) begin
          m_hi = n; m_pend = 1; m_age = 0;
        end else begin
          m_byte = m_hi * 16 + n; m_bv = 1; m_pend = 0;
        end
      end else begin
        m_err = 1;
        m_pend = 0;
        m_errs = (m_errs + 1 > 15) ? 15 : m_errs + 1;
      end
    end else if (m_pend) begin
      m_age++;
      if (m_age == TIMEOUT) begin
        m_to = 1; m_pend = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".digit"}, int'(digit), m_digit);
    chk({tag, ".dv"}, int'(digit_valid), int'(m_dv));
    chk({tag, ".byte"}, int'(byte_out), m_byte);
    chk({tag, ".bv"}, int'(byte_valid), int'(m_bv));
    chk({tag, ".pend"}, int'(pending), int'(m_pend));
    chk({tag, ".err"}, int'(err), int'(m_err));
    chk({tag, ".to"}, int'(timeout), int'(m_to));
    chk({tag, ".errc"}, int'(err_count), m_errs);
  endtask

  task automatic step(input string tag, input bit s, input logic [6:0] sg);
    stb = s;
    seg_in = sg;
    @(posedge clk_2);
    model_edge(s, sg);
    @(negedge clk_2);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1; stb = 1; seg_in = 7'h00;
    repeat (2) @(posedge clk_2);
    model_reset();
    @(negedge clk_2);
    reset = 0;
    check_all("rst");
  endtask

  task automatic commit(input string tag, input logic [6:0] sg);
    step({tag, ".lo"}, 1'b0, sg);
    step(tag, 1'b1, sg);
  endtask

  initial begin
    reset = 1; stb = 1; seg_in = 7'h00;
    @(negedge clk_2);
    do_reset();
    for (int i = 0; i < 5; i++) step("hold", 1'b1, 7'h66);

    commit("d4", 7'b1100110);
    chk("d4.digit", int'(digit), 4);
    chk("d4.pend", int'(pending), 1);
    commit("dB", 7'b1111100);
    chk("4B.byte", int'(byte_out), 8'h4B);
    chk("4B.bv", int'(byte_valid), 1);

    commit("dE", 7'b1111001);
    for (int i = 0; i < TIMEOUT; i++) step("wait", 1'b0, 7'h00);
    chk("to.byte", int'(byte_out), 8'h4B);
    chk("to.pend", int'(pending), 0);

    commit("p0", 7'b0111111);
    commit("inv", 7'b1010100);
    chk("inv.errc", int'(err_count), 1);
    commit("e0", 7'b0111111);
    commit("e1", 7'b0000110);
    chk("01.byte", int'(byte_out), 8'h01);

    for (int i = 0; i < 20; i++) commit("sat", (i % 2) ? 7'h00 : 7'h54);
    chk("sat.errc", int'(err_count), 15);

    // second digit lands exactly on the expiry edge
    commit("al.hi", 7'b1011011);
    for (int i = 0; i < TIMEOUT - 1; i++) step("al.w", 1'b0, 7'h00);
    step("al.lo", 1'b1, 7'b0000111);
    chk("al.byte", int'(byte_out), 8'h27);
    chk("al.bv", int'(byte_valid), 1);
    chk("al.to", int'(timeout), 0);

    commit("mr.hi", 7'b1111111);
    do_reset();
    commit("mr.d", 7'b1101111);
    chk("mr.bv", int'(byte_valid), 0);
    chk("mr.pend", int'(pending), 1);

    for (int k = 0; k < 300; k++) begin
      int gap;
      logic [6:0] sg;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20)
                                        : $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        step("rnd.g", 1'($urandom_range(0, 1)), 7'($urandom));
      if ($urandom_range(0, 3) == 0) sg = 7'($urandom);
      else sg = pat[$urandom_range(0, 15)];
      step("rnd.e", 1'b1, sg);
      if ($urandom_range(0, 1) == 0) step("rnd.l", 1'b0, sg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
